// File: rtl/apb_slave_mem.sv
// APB completer backed by a small register memory, with a fixed number of
// inserted wait states and an error response for out-of-range addresses.
module apb_slave_mem #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned      CNT_W   = 4;
    localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                pready_d, pslverr_d;
    logic [DATA_W-1:0]   prdata_d;
    logic                mem_we_c;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        err_d    = err_q;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    err_d   = ({1'b0, paddr} >= DEPTH_L);
                    if (WAIT_L == '0) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_L;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                state_d  = S_IDLE;
                mem_we_c = psel && penable && write_q && !err_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        pready_d  = (state_d == S_READY);
        pslverr_d = pready_d && err_d;
        prdata_d  = '0;
        if (pready_d && !write_d && !err_d) begin
            prdata_d = mem_q[addr_d[IDX_W-1:0]];
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            err_q   <= err_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    // Storage is cleared by reset as well, so an interrupted transfer leaves nothing behind.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_c) begin
            mem_q[addr_q[IDX_W-1:0]] <= pwdata;
        end
    end

endmodule
